// File: rtl/clockworks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clockworks_pkg
// Description : Shared defaults and counter-width helper for the clockworks
//               slow-clock / reset generator. Optional debounce is selected
//               with the macro CLOCKWORKS_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package clockworks_pkg;

  // Default divider exponent: slow period = 2^(SLOW+1) clk cycles.
  localparam int SLOW_DEFAULT            = 22;
  // Default number of slow_clk falls that slow_rst_n is held after release.
  localparam int RST_HOLD_DEFAULT        = 4;
  // Default number of stable clk cycles before a button change is accepted.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 65536;

  // Bits needed to hold any value 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : clockworks_pkg
`default_nettype wire

// File: rtl/clockworks_debounce.sv
`default_nettype none
// ============================================================================
// Module      : clockworks_debounce
// Description : Two-flop synchronizer for the raw push button, followed by an
//               optional stability filter enabled by CLOCKWORKS_DEBOUNCE_EN.
//               Without the macro the synchronizer output is used directly.
// Revision    : 1.0 - initial release
// ============================================================================
module clockworks_debounce
  import clockworks_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_clean_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the asynchronous button into the clk domain.
  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  // Synchronizer flops, cleared by the board reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef CLOCKWORKS_DEBOUNCE_EN
  // The counter runs 0..DEBOUNCE_CYCLES-1 while the synchronized level
  // disagrees with the accepted level; the last count accepts the new level.
  localparam int                DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            clean_q;
  logic            clean_d;

  // Any cycle of agreement throws away the partial count, so short glitches
  // never accumulate towards a change.
  always_comb begin
    db_cnt_d = '0;
    clean_d  = clean_q;
    if (sync_q[1] != clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        clean_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      clean_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      clean_q  <= clean_d;
    end
  end

  assign btn_clean_o = clean_q;
`else
  assign btn_clean_o = sync_q[1];
`endif

endmodule : clockworks_debounce
`default_nettype wire

// File: rtl/clockworks.sv
`default_nettype none
// ============================================================================
// Module      : clockworks
// Description : Divides clk into slow_clk, emits a tick one clk cycle before
//               every slow_clk rise, and sequences an active-low reset for
//               the slow domain that releases on a slow_clk falling edge.
//               The button path is debounced when CLOCKWORKS_DEBOUNCE_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module clockworks
  import clockworks_pkg::*;
#(
  parameter int SLOW            = SLOW_DEFAULT,
  parameter int RST_HOLD        = RST_HOLD_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic slow_clk,
  output logic slow_rst_n,
  output logic tick
);

  localparam int                  CNT_W     = SLOW + 1;
  localparam int                  HOLD_W    = cnt_width(RST_HOLD);
  // Count just before the MSB rises: 2^SLOW - 1.
  localparam logic [CNT_W-1:0]    TICK_VAL  = CNT_W'((64'd1 << SLOW) - 64'd1);
  // Count just before the MSB falls: all ones.
  localparam logic [CNT_W-1:0]    FALL_VAL  = '1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RST_HOLD);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              srst_n_q;
  logic              srst_n_d;
  logic              btn_clean;
  logic              rst_req;
  logic              fall_evt;

  clockworks_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_i       (btn),
    .btn_clean_o (btn_clean)
  );

  // Free-running divider; wraps naturally from all-ones to zero.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Divider register; only the board reset clears it, never the button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rst_req  = !rst_n || btn_clean;
  assign fall_evt = (cnt_q == FALL_VAL);

  // Hold sequencer: any request clears the count; after release each slow
  // fall advances it, and reaching RST_HOLD lets slow_rst_n rise on the same
  // edge that drops slow_clk. The count then saturates.
  always_comb begin
    hold_d   = hold_q;
    srst_n_d = srst_n_q;
    if (rst_req) begin
      hold_d   = '0;
      srst_n_d = 1'b0;
    end else if (fall_evt && (hold_q != HOLD_LAST)) begin
      hold_d = hold_q + HOLD_W'(1);
      if (hold_d == HOLD_LAST) begin
        srst_n_d = 1'b1;
      end
    end
  end

  // Hold counter and registered slow-domain reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= '0;
      srst_n_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      srst_n_q <= srst_n_d;
    end
  end

  // slow_clk is a bare register bit so it stays glitch-free.
  assign slow_clk   = cnt_q[SLOW];
  assign slow_rst_n = srst_n_q;
  // Gating with rst_n keeps tick quiet for the whole reset, even when SLOW=0.
  assign tick       = rst_n && (cnt_q == TICK_VAL);

endmodule : clockworks
`default_nettype wire

// File: tb/tb_clockworks.sv
`default_nettype none
// ============================================================================
// Module      : tb_clockworks
// Description : Scoreboard bench for clockworks with SLOW=2, RST_HOLD=4,
//               DEBOUNCE_CYCLES=16. Button scenarios follow the build:
//               CLOCKWORKS_DEBOUNCE_EN selects the debounced scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clockworks;

  localparam int SLOW            = 2;
  localparam int RST_HOLD        = 4;
  localparam int DEBOUNCE_CYCLES = 16;
  // Absolute cycle in which cnt is first 0 with rst_n high (relative k = 0).
  localparam int R               = 5;
`ifdef CLOCKWORKS_DEBOUNCE_EN
  localparam int K_END           = 150;
`else
  localparam int K_END           = 140;
`endif

  typedef struct {
    int   cyc;
    logic sclk;
    logic srst;
    logic tk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic slow_clk;
  logic slow_rst_n;
  logic tick;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  clockworks #(
    .SLOW            (SLOW),
    .RST_HOLD        (RST_HOLD),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .slow_clk   (slow_clk),
    .slow_rst_n (slow_rst_n),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Button level driven in relative cycle k.
  function automatic logic btn_at(input int k);
`ifdef CLOCKWORKS_DEBOUNCE_EN
    // 10-cycle glitch (shorter than 16), then a 40-cycle press.
    return (k >= 40 && k <= 49) || (k >= 56 && k <= 95);
`else
    // Three 3-cycle presses; the third lands after two hold falls.
    return (k >= 40 && k <= 42) || (k >= 80 && k <= 82) || (k >= 96 && k <= 98);
`endif
  endfunction

  // Hand-derived slow_rst_n in relative cycle k.
  function automatic logic srst_at(input int k);
`ifdef CLOCKWORKS_DEBOUNCE_EN
    // Release: falls at 7,15,23,31 -> high at 32. Glitch ignored.
    // Press sync high 58, clean high 74 -> low at 75. Clean low 114,
    // falls 119,127,135,143 -> high at 144.
    if (k < 32)  return 1'b0;
    if (k < 75)  return 1'b1;
    if (k < 144) return 1'b0;
    return 1'b1;
`else
    // Press at 40 -> low at 43; clean low 45, falls 47..71 -> high at 72.
    // Press at 80 -> low at 83; falls 87,95; press at 96 restarts;
    // clean low 101, falls 103,111,119,127 -> high at 128.
    if (k < 32)  return 1'b0;
    if (k < 43)  return 1'b1;
    if (k < 72)  return 1'b0;
    if (k < 83)  return 1'b1;
    if (k < 128) return 1'b0;
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input int c, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, c, got, exp);
    end
  endtask

  // Stimulus: drive each cycle's inputs and queue that cycle's expectation.
  initial begin
    exp_t e;
    int   k;
    rst_n = 1'b0;
    btn   = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= R + K_END; c++) begin
      k     = c - R;
      e.cyc = c;
      if (k < 0) begin
        rst_n  = 1'b0;
        btn    = 1'b0;
        e.sclk = 1'b0;
        e.srst = 1'b0;
        e.tk   = 1'b0;
      end else begin
        rst_n  = 1'b1;
        btn    = btn_at(k);
        e.sclk = ((k % 8) >= 4);
        e.srst = srst_at(k);
        e.tk   = ((k % 8) == 3);
      end
      q.push_back(e);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: on each falling edge, compare outputs for the current cycle.
  always @(negedge clk) begin
    exp_t m;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      if (m.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_entry cyc=%0d got=%0d expected=%0d", cyc, m.cyc, cyc);
      end else begin
        chk("slow_clk",   cyc, slow_clk,   m.sclk);
        chk("slow_rst_n", cyc, slow_rst_n, m.srst);
        chk("tick",       cyc, tick,       m.tk);
      end
    end
  end

  // Bound the run in case the stimulus loop stalls.
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_clockworks
`default_nettype wire

// File: doc/clockworks.md
CLOCKWORKS -- requirements
Module: clockworks

Interface
REQ-001 Parameter SLOW, default 22, divider exponent; slow clock period = 2^(SLOW+1) clk cycles; legal range 0..30.
REQ-002 Parameter RST_HOLD, default 4, number of slow_clk falling edges slow_rst_n stays low after the reset request clears; legal 1..255.
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536, number of clk cycles btn must be stable before it is accepted; legal 2..2^24.
REQ-004 clk  input  1  board clock (12 MHz); all logic is on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 btn  input  1  raw push-button reset request, active-high, asynchronous to clk, may bounce.
REQ-007 slow_clk  output  1  divided clock for the slow domain.
REQ-008 slow_rst_n  output  1  active-low reset for the slow domain.
REQ-009 tick  output  1  one-clk-cycle pulse preceding each slow_clk rising edge (clock-enable alternative).

Function
REQ-010 The divider SHALL be a free-running (SLOW+1)-bit up-counter cnt, incremented every clk cycle, wrapping from all-ones to 0.
REQ-011 slow_clk SHALL equal cnt[SLOW], which is a register bit with no combinational output logic; it is low for 2^SLOW cycles, then high for 2^SLOW cycles.
REQ-012 tick SHALL be 1 exactly in the clk cycle where cnt == 2^SLOW-1, so the next clk edge raises slow_clk.
REQ-013 Define fall event as the cycle where cnt == 2^(SLOW+1)-1, after which slow_clk falls.
REQ-014 btn SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Reset request SHALL be (!rst_n) OR btn_clean, where btn_clean is the synchronized and, if configured, debounced btn.
REQ-016 While the request is active, slow_rst_n SHALL be 0 from the next clk edge and the hold counter SHALL be cleared.
REQ-017 Once the request clears, the hold counter SHALL increment on each fall event; slow_rst_n SHALL go 1 at the clk edge ending the RST_HOLD-th fall event, i.e. coincident with a slow_clk falling edge.
REQ-018 A new request during the hold count SHALL restart the count from 0.
REQ-019 btn SHALL NOT reset the divider; only rst_n resets cnt.
REQ-020 The hold counter SHALL saturate at RST_HOLD; slow_rst_n then stays 1 until the next request.

Reset
REQ-021 rst_n low SHALL give, at the next clk edge: cnt=0, slow_clk=0, tick=0 for the whole reset, slow_rst_n=0, hold counter=0, synchronizer and debouncer flops cleared (btn_clean=0).
REQ-022 After rst_n rises, cnt SHALL start at 0 on the first cycle with rst_n high.

Configuration
REQ-023 Macro CLOCKWORKS_DEBOUNCE_EN: when defined, btn_clean changes only after the synchronized btn has differed from btn_clean for DEBOUNCE_CYCLES consecutive clk cycles; a shorter glitch is ignored and restarts the debounce count.
REQ-024 When CLOCKWORKS_DEBOUNCE_EN is undefined, btn_clean SHALL be the 2-flop synchronizer output directly, and DEBOUNCE_CYCLES is ignored.

Structure
REQ-025 Shared package clockworks_pkg SHALL hold the default constants (SLOW, RST_HOLD, DEBOUNCE_CYCLES) and a width helper, clog2-based, for the counters.
REQ-026 One sub-module, clockworks_debounce, SHALL contain the synchronizer plus the optional debouncer; the divider and reset sequencer live in clockworks.

Verification
REQ-027 SLOW=2, release rst_n -> slow_clk 0 for cycles 0-3 and 1 for cycles 4-7, repeating; tick high at cycles 3, 11, 19, ...
REQ-028 SLOW=2, RST_HOLD=4, btn=0, release rst_n at cycle 0 -> slow_rst_n rises at the edge ending cycle 31, at a slow_clk fall.
REQ-029 With debounce enabled and DEBOUNCE_CYCLES=16, a 10-cycle btn pulse -> slow_rst_n unchanged, cnt continuous.
REQ-030 With debounce enabled, btn held 40 cycles -> slow_rst_n 0 within 2+16+1 cycles of btn rising; RST_HOLD falls after btn_clean clears -> slow_rst_n 1; cnt never reset.
REQ-031 With debounce disabled, btn held 3 cycles -> slow_rst_n 0 three edges after btn rises.
REQ-032 Request re-asserted after 2 of 4 hold falls -> count restarts; slow_rst_n rises 4 fall events after the final release.
